// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV frame sequencer.
package hsv_pkg;

  localparam int PIX_W = 16;
  localparam int COL_W = 10;
  localparam int ROW_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOP,
    ST_ACTIVE,
    ST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    ERR_SHORT   = 2'd0,
    ERR_NO_EOP  = 2'd1,
    ERR_RESTART = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_t;

  localparam logic [8:0] H_MAX_DEG = 9'd359;

  typedef struct packed {
    logic [8:0] h_min;
    logic [8:0] h_max;
    logic [8:0] s_min;
    logic [7:0] v_min;
  } thr_t;

  localparam thr_t THR_DEFAULT = '{h_min: 9'd0, h_max: H_MAX_DEG, s_min: 9'd0, v_min: 8'd0};

endpackage

// File: rtl/hsv_frame_ctrl_if.sv
// RGB565 pixel stream with frame markers, used on both the camera and converter sides.
interface hsv_frame_ctrl_if;
  import hsv_pkg::*;

  logic [PIX_W-1:0] pix;
  logic             sop;
  logic             eop;
  logic             vld;

  modport master (output pix, sop, eop, vld);
  modport slave  (input  pix, sop, eop, vld);
endinterface

// File: rtl/hsv_pos_cnt.sv
// Column/row position of the last forwarded pixel, plus a look-ahead flag that is set
// when the next advance would land on the final pixel of the frame.
module hsv_pos_cnt
  import hsv_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             nxt_last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_nx;
  logic [ROW_W-1:0] row_nx;
  logic             wrap;

  always_comb begin
    wrap   = (col == COL_LAST);
    col_nx = wrap ? '0 : col + COL_W'(1);
    row_nx = row;
    if (wrap) begin
      row_nx = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end
    nxt_last = (col_nx == COL_LAST) && (row_nx == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      col <= col_nx;
      row <= row_nx;
    end
  end

endmodule

// File: rtl/hsv_frame_ctrl.sv
// Frame sequencer ahead of the rgb2hsv converter: gates the pixel stream, drains the
// converter after each frame, reports framing errors and double-buffers thresholds.
module hsv_frame_ctrl
  import hsv_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned LAT   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  hsv_frame_ctrl_if.slave         din,
  input  logic [8:0]              cfg_h_min,
  input  logic [8:0]              cfg_h_max,
  input  logic [8:0]              cfg_s_min,
  input  logic [7:0]              cfg_v_min,
  input  logic                    cfg_upd,
  hsv_frame_ctrl_if.master        cv,
  output logic [8:0]              thr_h_min,
  output logic [8:0]              thr_h_max,
  output logic [8:0]              thr_s_min,
  output logic [7:0]              thr_v_min,
  output logic [COL_W-1:0]        col_cnt,
  output logic [ROW_W-1:0]        row_cnt,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  state_t        state, nxt_state;
  err_t          err_q, err_val;
  logic [DW-1:0] drain;
  logic          fwd, force_eop, pos_clr, pos_inc, err_set, drain_last, nxt_last;
  thr_t          thr_q, pend_q, cfg_in;
  logic          pend_vld;

  assign cfg_in    = '{h_min: cfg_h_min, h_max: cfg_h_max, s_min: cfg_s_min, v_min: cfg_v_min};
  assign thr_h_min = thr_q.h_min;
  assign thr_h_max = thr_q.h_max;
  assign thr_s_min = thr_q.s_min;
  assign thr_v_min = thr_q.v_min;
  assign err_code  = err_q;
  assign busy      = (state == ST_ACTIVE) || (state == ST_FLUSH);

  hsv_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pos_clr),
    .inc      (pos_inc),
    .col      (col_cnt),
    .row      (row_cnt),
    .nxt_last (nxt_last)
  );

  always_comb begin
    nxt_state  = state;
    fwd        = 1'b0;
    force_eop  = 1'b0;
    pos_clr    = 1'b0;
    pos_inc    = 1'b0;
    err_set    = 1'b0;
    err_val    = ERR_SHORT;
    drain_last = (state == ST_FLUSH) && (drain == DRAIN_LAST);
    unique case (state)
      ST_IDLE: begin
        if (en) nxt_state = ST_WAIT_SOP;
      end
      ST_WAIT_SOP: begin
        if (din.vld && din.sop) begin
          fwd       = 1'b1;
          pos_clr   = 1'b1;
          nxt_state = ST_ACTIVE;
        end else if (!en) begin
          nxt_state = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (din.vld) begin
          fwd = 1'b1;
          // eop outranks sop, so sop+eop reports SHORT rather than RESTART
          if (din.eop) begin
            pos_inc   = 1'b1;
            nxt_state = ST_FLUSH;
            err_set   = !nxt_last || din.sop;
          end else if (din.sop) begin
            pos_clr = 1'b1;
            err_set = 1'b1;
            err_val = ERR_RESTART;
          end else begin
            pos_inc = 1'b1;
            if (nxt_last) begin
              force_eop = 1'b1;
              err_set   = 1'b1;
              err_val   = ERR_NO_EOP;
              nxt_state = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (din.vld) begin
          err_set = 1'b1;
          err_val = ERR_OVERRUN;
        end
        if (drain_last) nxt_state = en ? ST_WAIT_SOP : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cv.pix     <= '0;
      cv.sop     <= 1'b0;
      cv.eop     <= 1'b0;
      cv.vld     <= 1'b0;
      drain      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_q      <= ERR_SHORT;
      frame_cnt  <= '0;
      thr_q      <= THR_DEFAULT;
      pend_q     <= THR_DEFAULT;
      pend_vld   <= 1'b0;
    end else begin
      state      <= nxt_state;
      cv.pix     <= fwd ? din.pix : '0;
      cv.sop     <= fwd && din.sop;
      cv.eop     <= fwd && (din.eop || force_eop);
      cv.vld     <= fwd;
      drain      <= ((state == ST_FLUSH) && !drain_last) ? drain + DW'(1) : '0;
      frame_done <= drain_last;
      frame_err  <= err_set;
      if (err_set) err_q <= err_val;
      if (drain_last) frame_cnt <= frame_cnt + 16'd1;
      // Thresholds only move in IDLE or on the final drain cycle, never mid-frame
      if (state == ST_IDLE) begin
        if (cfg_upd) thr_q <= cfg_in;
      end else if (drain_last) begin
        if (cfg_upd)       thr_q <= cfg_in;
        else if (pend_vld) thr_q <= pend_q;
        pend_vld <= 1'b0;
      end else if (cfg_upd) begin
        pend_q   <= cfg_in;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hsv_frame_ctrl.sv
// Scoreboard bench for hsv_frame_ctrl: a frame-index reference model queues expected
// beats and pulses; a negedge monitor pops and compares them against the DUT.
module tb_hsv_frame_ctrl;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 2;
  localparam int unsigned LAT = 3;
  localparam int M_IDLE = 0, M_WAIT = 1, M_ACT = 2, M_FLUSH = 3;
  localparam logic [34:0] THR_DEF = {9'd0, 9'd359, 9'd0, 8'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, cfg_upd;
  logic [8:0]  cfg_h_min, cfg_h_max, cfg_s_min;
  logic [7:0]  cfg_v_min;
  logic [8:0]  thr_h_min, thr_h_max, thr_s_min;
  logic [7:0]  thr_v_min;
  logic [9:0]  col_cnt;
  logic [8:0]  row_cnt;
  logic        busy, frame_done, frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  hsv_frame_ctrl_if din_if ();
  hsv_frame_ctrl_if cv_if ();

  hsv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_if),
    .cfg_h_min(cfg_h_min), .cfg_h_max(cfg_h_max), .cfg_s_min(cfg_s_min),
    .cfg_v_min(cfg_v_min), .cfg_upd(cfg_upd), .cv(cv_if),
    .thr_h_min(thr_h_min), .thr_h_max(thr_h_max), .thr_s_min(thr_s_min),
    .thr_v_min(thr_v_min), .col_cnt(col_cnt), .row_cnt(row_cnt), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  typedef struct { logic [15:0] pix; bit sop; bit eop; int cyc; } px_t;
  typedef struct { int cyc; int code; } ev_t;

  px_t px_q[$];
  int  done_q[$];
  ev_t err_q[$];
  int  checks = 0, failures = 0, cyc = 0;
  bit  mon_en = 1'b0;

  // reference model state (position kept as a linear pixel index)
  int          m_mode, m_idx, m_flush_end, m_fcnt, m_err, m_col, m_row;
  logic [34:0] m_thr, m_pend;
  bit          m_pend_v;
  // model state as seen after the latest clock edge
  int          s_fcnt, s_err, s_col, s_row;
  logic [34:0] s_thr;
  bit          s_busy;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_thr  <= m_thr;
    s_busy <= (m_mode == M_ACT) || (m_mode == M_FLUSH);
    s_fcnt <= m_fcnt;
    s_err  <= m_err;
    s_col  <= m_col;
    s_row  <= m_row;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  function automatic void m_reset(int e);
    m_mode = M_IDLE; m_idx = 0; m_flush_end = 0; m_fcnt = 0; m_err = 0;
    m_col = 0; m_row = 0; m_thr = THR_DEF; m_pend = THR_DEF; m_pend_v = 0;
    while (done_q.size() > 0 && done_q[$] >= e) void'(done_q.pop_back());
  endfunction

  function automatic void m_fwd(logic [15:0] pix, bit sop, bit eop, int idx, int e);
    px_q.push_back('{pix, sop, eop, e});
    m_idx = idx;
    m_col = idx % W;
    m_row = idx / W;
  endfunction

  function automatic void m_errev(int code, int e);
    err_q.push_back('{e, code});
    m_err = code;
  endfunction

  function automatic void m_end(int e);
    m_mode      = M_FLUSH;
    m_flush_end = e + LAT;
    done_q.push_back(e + LAT);
  endfunction

  // One clock edge e of the reference model, given the inputs sampled at that edge.
  function automatic void model_step(int e, bit rst, bit en_i, bit vld, bit sop, bit eop,
                                     logic [15:0] pix, bit upd, logic [34:0] cfg);
    bit last;
    if (!rst) begin
      m_reset(e);
      return;
    end
    if (m_mode == M_IDLE) begin
      if (upd) m_thr = cfg;
    end else if (m_mode == M_FLUSH && e == m_flush_end) begin
      if (upd) m_thr = cfg;
      else if (m_pend_v) m_thr = m_pend;
      m_pend_v = 0;
    end else if (upd) begin
      m_pend = cfg; m_pend_v = 1;
    end
    case (m_mode)
      M_IDLE: if (en_i) m_mode = M_WAIT;
      M_WAIT: begin
        if (vld && sop) begin
          m_fwd(pix, 1, eop, 0, e);
          m_mode = M_ACT;
        end else if (!en_i) m_mode = M_IDLE;
      end
      M_ACT: if (vld) begin
        if (sop && !eop) begin
          m_errev(2, e);
          m_fwd(pix, 1, 0, 0, e);
        end else begin
          last = ((m_idx + 1) == int'(W * H - 1));
          if (eop) begin
            m_fwd(pix, sop, 1, m_idx + 1, e);
            if (!last || sop) m_errev(0, e);
            m_end(e);
          end else if (last) begin
            m_fwd(pix, 0, 1, m_idx + 1, e);
            m_errev(1, e);
            m_end(e);
          end else m_fwd(pix, 0, 0, m_idx + 1, e);
        end
      end
      default: begin
        if (vld) m_errev(3, e);
        if (e == m_flush_end) begin
          m_fcnt = (m_fcnt + 1) % 65536;
          m_mode = en_i ? M_WAIT : M_IDLE;
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    px_t p;
    ev_t ev;
    if (mon_en) begin
      while (px_q.size() > 0 && px_q[0].cyc < cyc) begin flag("px_missing"); void'(px_q.pop_front()); end
      while (done_q.size() > 0 && done_q[0] < cyc) begin flag("done_missing"); void'(done_q.pop_front()); end
      while (err_q.size() > 0 && err_q[0].cyc < cyc) begin flag("err_missing"); void'(err_q.pop_front()); end
      if (cv_if.vld) begin
        if (px_q.size() == 0) flag("px_unexpected");
        else begin
          p = px_q.pop_front();
          chk("px_cyc", cyc, p.cyc);
          chk("cv_din", cv_if.pix, p.pix);
          chk("cv_sop", cv_if.sop, p.sop);
          chk("cv_eop", cv_if.eop, p.eop);
        end
      end else chk("cv_gated", {cv_if.pix, cv_if.sop, cv_if.eop}, '0);
      if (frame_done) begin
        if (done_q.size() == 0) flag("done_unexpected");
        else chk("done_cyc", cyc, done_q.pop_front());
      end
      if (frame_err) begin
        if (err_q.size() == 0) flag("err_unexpected");
        else begin
          ev = err_q.pop_front();
          chk("err_cyc", cyc, ev.cyc);
          chk("err_code_ev", err_code, ev.code);
        end
      end
      chk("busy", busy, s_busy);
      chk("thr", {thr_h_min, thr_h_max, thr_s_min, thr_v_min}, s_thr);
      chk("frame_cnt", frame_cnt, s_fcnt);
      chk("err_code", err_code, s_err);
      chk("col_cnt", col_cnt, s_col);
      chk("row_cnt", row_cnt, s_row);
    end
  end

  function automatic logic [34:0] rand_cfg();
    return {9'($urandom_range(359)), 9'($urandom_range(359)), 9'($urandom), 8'($urandom)};
  endfunction

  task automatic step(bit vld, bit sop = 0, bit eop = 0, bit upd = 0, logic [34:0] cfg = '0);
    logic [34:0] c;
    c = upd ? cfg : rand_cfg();
    din_if.pix = 16'($urandom);
    din_if.vld = vld; din_if.sop = sop; din_if.eop = eop;
    cfg_upd = upd;
    {cfg_h_min, cfg_h_max, cfg_s_min, cfg_v_min} = c;
    model_step(cyc + 1, rst_n, en, vld, sop, eop, din_if.pix, upd, c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(0);
  endtask

  task automatic send_frame(int n, int sop2, int eop_at, int gap_pct, int upd_at, logic [34:0] ucfg);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < gap_pct) step(0);
      step(1, (i == 0) || (i == sop2), i == eop_at, i == upd_at, ucfg);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    m_reset(0);
    step(0);
    mon_en = 1'b1;
    step(0);
    rst_n = 1'b1; en = 1'b1;
    idle(2);
    send_frame(8, -1, 7, 0, -1, '0);           // clean frame
    idle(LAT + 2);
    send_frame(6, -1, 5, 0, -1, '0);           // SHORT
    idle(LAT + 2);
    send_frame(8, -1, -1, 0, -1, '0);          // NO_EOP, eop forced
    idle(LAT + 2);
    send_frame(11, 3, 10, 0, -1, '0);          // RESTART, then 8 clean pixels
    idle(LAT + 2);
    send_frame(8, -1, 7, 0, 2, {9'd30, 9'd359, 9'd0, 8'd0});  // pending cfg
    idle(LAT + 2);
    en = 1'b0;
    idle(3);
    step(0, 0, 0, 1, {9'd45, 9'd300, 9'd10, 8'd20});          // direct cfg in IDLE
    en = 1'b1;
    idle(2);
    send_frame(4, -1, -1, 0, -1, '0);          // reset mid-frame
    rst_n = 1'b0; en = 1'b0;
    step(1);
    step(0);
    rst_n = 1'b1; en = 1'b1;
    idle(2);
    send_frame(8, -1, 7, 0, -1, '0);
    step(1, 1, 0);                             // OVERRUN sop right after eop
    idle(LAT + 2);
    send_frame(8, -1, 7, 0, -1, '0);
    idle(LAT - 1);
    step(1);                                   // OVERRUN on the last drain cycle
    idle(LAT + 2);

    for (int f = 0; f < 80; f++) begin
      int kind, k, gap, upd_at;
      kind   = int'($urandom_range(5));
      gap    = int'($urandom_range(40));
      upd_at = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1;
      if ($urandom_range(7) == 0) begin
        en = 1'b0;
        idle(int'($urandom_range(1, 5)));
        step(0, 0, 0, $urandom_range(1) == 1, rand_cfg());
        en = 1'b1;
      end
      repeat ($urandom_range(2)) step(1);
      case (kind)
        0, 1: send_frame(8, -1, 7, gap, upd_at, rand_cfg());
        2: begin k = int'($urandom_range(1, 6)); send_frame(k + 1, -1, k, gap, upd_at, rand_cfg()); end
        3: send_frame(8, -1, -1, gap, upd_at, rand_cfg());
        4: begin k = int'($urandom_range(1, 7)); send_frame(k + 8, k, k + 7, gap, upd_at, rand_cfg()); end
        default: begin k = int'($urandom_range(1, 6)); send_frame(k + 1, k, k, gap, upd_at, rand_cfg()); end
      endcase
      repeat ($urandom_range(LAT + 2)) step($urandom_range(3) == 0, $urandom_range(1) == 1, 0,
                                            $urandom_range(5) == 0, rand_cfg());
      idle(int'($urandom_range(LAT)));
    end
    en = 1'b1;
    idle(LAT + 6);
    if (px_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) flag("queue_leftover");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
